ro_puf_engine: RTL and testbench
================================

# ro_puf_engine

Parametrised ring-oscillator PUF response engine, the successor to the single-comparison 16-oscillator design. A 16-bit challenge seeds an LFSR that selects oscillator pairs. For each pair the block counts edges over a fixed clock-gated window, compares the two counts, and assembles a RESP_BITS-wide response. It sits between the oscillator bank (inputs `ro_in`) and the host-facing I/O logic.

## Interface
- NUM_RO, 16: oscillators in bank; power of two, 4..256
- SEL_W, $clog2(NUM_RO): pair index width, ≤8
- CNT_W, 16: edge counter width
- GATE_CYCLES, 1024: clk cycles per count window, ≥4
- SETTLE_CYCLES, 4: clk cycles after gate close before compare, ≥3
- RESP_BITS, 8: response bits per challenge
- MARGIN, 8: minimum |cnt_a−cnt_b| for a reliable bit (PUF_MARGIN_EN only)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ro_in  in  NUM_RO  free-running oscillator outputs
- start  in  1  begin evaluation; sampled in IDLE only
- challenge  in  16  LFSR seed, sampled with start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when response is updated
- response  out  RESP_BITS  last completed response
- resp_valid  out  1  response holds a complete result
- last_cnt_a / last_cnt_b  out  CNT_W each  counts of most recent compare (debug)
- unreliable  out  RESP_BITS  per-bit margin flag (PUF_MARGIN_EN only)

## Operation
- Reset: all outputs are 0. FSM enters IDLE, LFSR is 0, and both edge counters are cleared asynchronously.
- FSM states: IDLE → CLEAR → GATE → SETTLE → COMPARE → (CLEAR | DONE) → IDLE.
- IDLE, start=1: load LFSR with challenge. A zero challenge loads 16'hACE1. Set busy, bit index i=0, clear resp_valid.
- Pair selection: idx_a = lfsr[SEL_W-1:0] and idx_b = lfsr[8+SEL_W-1:8]. If idx_b==idx_a, idx_b = idx_a+1 mod NUM_RO.
- CLEAR, 1 cycle: counter clear asserted, gate low.
- GATE, GATE_CYCLES cycles: gate high. Each counter increments on rising edges of its selected ro_in. Gate is synchronised into each RO domain with 2 flops.
- SETTLE, SETTLE_CYCLES cycles: gate low, counts frozen.
- COMPARE, 1 cycle:
  - response_shadow[i] = (cnt_a > cnt_b).
  - A tie gives 0.
  - Capture last_cnt_a/b.
  - Step the LFSR once (Fibonacci, taps 16,14,13,11).
  - i++. If i==RESP_BITS go to DONE, else go to CLEAR.
- DONE, 1 cycle: response ← shadow, resp_valid=1, done=1, busy=0, then return to IDLE.
- Counters saturate at all-ones and do not wrap. Both saturated is a tie and gives 0.
- A stuck oscillator gives count 0. This is legal; the compare rule applies unchanged.
- start while busy is ignored.
- start in the same cycle as DONE is ignored. It is accepted the following cycle in IDLE.
- challenge changes while busy have no effect.
- rst_n low mid-evaluation: immediate abort, all outputs return to 0, counters clear, and the partial response is discarded.

## Timing
- The first bit uses the seed value; each later bit uses the LFSR stepped once more.
- Per-bit latency: 1 + GATE_CYCLES + SETTLE_CYCLES + 1 cycles.
- start accepted at edge T → done high at T + RESP_BITS·(GATE_CYCLES+SETTLE_CYCLES+2) + 1.
- busy rises the cycle after acceptance and falls together with done.
- response, resp_valid and unreliable change only in the DONE cycle. resp_valid stays high until the next accepted start.
- COMPARE reads counters that have been stable for ≥SETTLE_CYCLES−2 clk cycles. This requires the 2-flop gate synchroniser plus one RO edge of slack.

## Configuration
- PUF_MARGIN_EN defined:
  - COMPARE also sets unreliable_shadow[i] = (|cnt_a−cnt_b| < MARGIN).
  - `unreliable` updates in DONE; reset value is 0.
- PUF_MARGIN_EN undefined:
  - The `unreliable` port and the MARGIN logic are absent.
  - Response behaviour is identical.

## Structure
- Shared package ro_puf_pkg holds:
  - FSM state enum (IDLE, CLEAR, GATE, SETTLE, COMPARE, DONE);
  - LFSR tap constant;
  - zero-seed substitute 16'hACE1.
- Sub-module ro_edge_counter holds: CNT_W saturating counter clocked by an ro line, 2-flop gate synchroniser, and asynchronous clear driven by rst_n and the clear strobe. It is instantiated twice, for pair A and pair B.
- Pair selection uses two NUM_RO:1 muxes in the top module. All oscillator loops stay in the bank, outside this block.

## Test plan
Bench configuration for all scenarios: NUM_RO=4, GATE_CYCLES=64, SETTLE_CYCLES=4, RESP_BITS=4, clk period 10 ns. The ro_in oscillator periods are bench-driven; listed periods override per scenario.
- Challenge 16'h0201 gives idx_a=1, idx_b=2. With ro1 period 20 ns and ro2 period 40 ns: response[0]=1, last_cnt_a≈2×last_cnt_b. done appears exactly 4·70+1 = 281 cycles after start acceptance.
- Challenge 16'h0000 behaves identically to challenge 16'hACE1; identical response for equal ro periods.
- All four ro_in tied low: response=4'b0000, counts 0, done still pulses.
- Challenge 16'h0101 gives idx_a=idx_b=1, so idx_b becomes 2: same bit-0 result as the first scenario.
- rst_n pulsed low at cycle 100 after start: busy, done, response and resp_valid return to 0. A new start then completes normally in 281 cycles.
- PUF_MARGIN_EN, MARGIN=8: ro1 and ro2 periods set to 20 ns and 21 ns give unreliable[0]=1. Periods of 20 ns and 40 ns give unreliable[0]=0.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF response engine:
// FSM state encoding, LFSR feedback taps and the zero-challenge seed substitute.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        COMPARE,
        DONE
    } state_e;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] ZERO_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Saturating edge counter clocked directly by one oscillator line, with a
// 2-flop gate synchroniser in the oscillator domain and an asynchronous clear.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             ro_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             gate_i,
    output logic [CNT_W-1:0] count_o
);

    logic             asyncClr;
    logic             gateMeta_q;
    logic             gateSync_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // clear_i comes straight from a flop in the clk domain, so it is glitch-free.
    assign asyncClr = clear_i | ~rst_ni;

    always_comb begin
        count_d = count_q;
        if (gateSync_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ro_i or posedge asyncClr) begin
        if (asyncClr) begin
            gateMeta_q <= 1'b0;
            gateSync_q <= 1'b0;
            count_q    <= '0;
        end else begin
            gateMeta_q <= gate_i;
            gateSync_q <= gateMeta_q;
            count_q    <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF response engine: LFSR-selected oscillator pairs are
// counted over a gated window and compared bit by bit. Optional per-bit
// margin flags are built when PUF_MARGIN_EN is defined.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO        = 16,
    parameter int SEL_W         = $clog2(NUM_RO),
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESP_BITS     = 8
`ifdef PUF_MARGIN_EN
    ,
    parameter int MARGIN        = 8
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RO-1:0]    ro_i,
    input  logic                 start_i,
    input  logic [15:0]          challenge_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [RESP_BITS-1:0] response_o,
    output logic                 resp_valid_o,
    output logic [CNT_W-1:0]     last_cnt_a_o,
`ifdef PUF_MARGIN_EN
    output logic [CNT_W-1:0]     last_cnt_b_o,
    output logic [RESP_BITS-1:0] unreliable_o
`else
    output logic [CNT_W-1:0]     last_cnt_b_o
`endif
);

    localparam int CYC_W = $clog2(GATE_CYCLES + SETTLE_CYCLES);
    localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_e               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
    logic [RESP_BITS-1:0] respShadow_q, respShadow_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 respValid_q, respValid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clear_q, clear_d;
    logic                 gate_q, gate_d;
    logic [CNT_W-1:0]     lastCntA_q, lastCntA_d;
    logic [CNT_W-1:0]     lastCntB_q, lastCntB_d;
`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unrelShadow_q, unrelShadow_d;
    logic [RESP_BITS-1:0] unreliable_q, unreliable_d;
    logic [CNT_W-1:0]     cntDiff;
`endif

    logic [SEL_W-1:0]     idxA, idxB, idxBRaw;
    logic                 roA, roB;
    logic [CNT_W-1:0]     cntA, cntB;

    // The LFSR only moves at the edge that enters CLEAR, so any mux glitch
    // lands while the counters are held in asynchronous clear.
    assign idxA    = lfsr_q[SEL_W-1:0];
    assign idxBRaw = lfsr_q[8 +: SEL_W];
    assign idxB    = (idxBRaw == idxA) ? idxA + SEL_W'(1) : idxBRaw;
    assign roA     = ro_i[idxA];
    assign roB     = ro_i[idxB];

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .ro_i    (roA),
        .rst_ni  (rst_ni),
        .clear_i (clear_q),
        .gate_i  (gate_q),
        .count_o (cntA)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .ro_i    (roB),
        .rst_ni  (rst_ni),
        .clear_i (clear_q),
        .gate_i  (gate_q),
        .count_o (cntB)
    );

`ifdef PUF_MARGIN_EN
    assign cntDiff = (cntA > cntB) ? cntA - cntB : cntB - cntA;
`endif

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cyc_d        = cyc_q;
        bitIdx_d     = bitIdx_q;
        respShadow_d = respShadow_q;
        response_d   = response_q;
        respValid_d  = respValid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        lastCntA_d   = lastCntA_q;
        lastCntB_d   = lastCntB_q;
`ifdef PUF_MARGIN_EN
        unrelShadow_d = unrelShadow_q;
        unreliable_d  = unreliable_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lfsr_d       = (challenge_i == 16'h0000) ? ZERO_SEED : challenge_i;
                    bitIdx_d     = '0;
                    respShadow_d = '0;
                    respValid_d  = 1'b0;
                    busy_d       = 1'b1;
`ifdef PUF_MARGIN_EN
                    unrelShadow_d = '0;
`endif
                    state_d      = CLEAR;
                end
            end
            CLEAR: begin
                cyc_d   = CYC_W'(GATE_CYCLES - 1);
                state_d = GATE;
            end
            GATE: begin
                if (cyc_q == '0) begin
                    cyc_d   = CYC_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            SETTLE: begin
                if (cyc_q == '0) begin
                    state_d = COMPARE;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            COMPARE: begin
                respShadow_d[bitIdx_q] = (cntA > cntB);
`ifdef PUF_MARGIN_EN
                unrelShadow_d[bitIdx_q] = (cntDiff < CNT_W'(MARGIN));
`endif
                lastCntA_d = cntA;
                lastCntB_d = cntB;
                lfsr_d     = lfsr_step(lfsr_q);
                if (bitIdx_q == BIT_W'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    bitIdx_d = bitIdx_q + BIT_W'(1);
                    state_d  = CLEAR;
                end
            end
            DONE: begin
                response_d  = respShadow_q;
                respValid_d = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
`ifdef PUF_MARGIN_EN
                unreliable_d = unrelShadow_q;
`endif
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        clear_d = (state_d == CLEAR);
        gate_d  = (state_d == GATE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lfsr_q       <= '0;
            cyc_q        <= '0;
            bitIdx_q     <= '0;
            respShadow_q <= '0;
            response_q   <= '0;
            respValid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            clear_q      <= 1'b0;
            gate_q       <= 1'b0;
            lastCntA_q   <= '0;
            lastCntB_q   <= '0;
`ifdef PUF_MARGIN_EN
            unrelShadow_q <= '0;
            unreliable_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cyc_q        <= cyc_d;
            bitIdx_q     <= bitIdx_d;
            respShadow_q <= respShadow_d;
            response_q   <= response_d;
            respValid_q  <= respValid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            clear_q      <= clear_d;
            gate_q       <= gate_d;
            lastCntA_q   <= lastCntA_d;
            lastCntB_q   <= lastCntB_d;
`ifdef PUF_MARGIN_EN
            unrelShadow_q <= unrelShadow_d;
            unreliable_q  <= unreliable_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign response_o   = response_q;
    assign resp_valid_o = respValid_q;
    assign last_cnt_a_o = lastCntA_q;
    assign last_cnt_b_o = lastCntB_q;
`ifdef PUF_MARGIN_EN
    assign unreliable_o = unreliable_q;
`endif

endmodule

// File: tb/tb_ro_puf_engine.sv
// Self-checking bench for ro_puf_engine with bench-driven oscillators and a
// frequency-based reference model; margin checks are built under PUF_MARGIN_EN.
`timescale 1ns/100ps
module tb_ro_puf_engine;

    localparam int NRO   = 4;
    localparam int GATE  = 64;
    localparam int RBITS = 4;
    localparam int LAT   = RBITS * (GATE + 4 + 2) + 1;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    wire  [NRO-1:0]   roBus;
    logic             start = 1'b0;
    logic [15:0]      challenge = 16'h0000;
    logic             busy, done, respValid;
    logic [RBITS-1:0] response;
    logic [15:0]      lastCntA, lastCntB;
`ifdef PUF_MARGIN_EN
    logic [RBITS-1:0] unreliable;
`endif

    real perNs [NRO];
    bit  roOn  [NRO];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NRO; g++) begin : gRo
        logic r = 1'b0;
        initial begin
            #0.3;
            forever begin
                if (roOn[g]) begin
                    #(perNs[g] / 2.0) r = 1'b1;
                    #(perNs[g] / 2.0) r = 1'b0;
                end else begin
                    r = 1'b0;
                    #1;
                end
            end
        end
        assign roBus[g] = r;
    end

    ro_puf_engine #(
        .NUM_RO(NRO), .CNT_W(16), .GATE_CYCLES(GATE), .SETTLE_CYCLES(4), .RESP_BITS(RBITS)
`ifdef PUF_MARGIN_EN
        , .MARGIN(8)
`endif
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .ro_i(roBus), .start_i(start), .challenge_i(challenge),
        .busy_o(busy), .done_o(done), .response_o(response), .resp_valid_o(respValid),
        .last_cnt_a_o(lastCntA),
`ifdef PUF_MARGIN_EN
        .last_cnt_b_o(lastCntB), .unreliable_o(unreliable)
`else
        .last_cnt_b_o(lastCntB)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [15:0] modelStep(input logic [15:0] s);
        int fb;
        fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return 16'((s >> 1) | (fb << 15));
    endfunction

    function automatic real freqOf(input int idx);
        return roOn[idx] ? 1.0 / perNs[idx] : 0.0;
    endfunction

    function automatic int expCount(input int idx);
        return roOn[idx] ? int'($floor(GATE * 10.0 / perNs[idx])) : 0;
    endfunction

    // Faster oscillator in slot A gives a 1; the last pair is reported for count checks.
    function automatic logic [RBITS-1:0] modelResp(input logic [15:0] ch, output int la, output int lb);
        logic [15:0] s;
        logic [RBITS-1:0] r;
        int a, b;
        s = (ch == 16'h0000) ? 16'hACE1 : ch;
        r = '0;
        la = 0;
        lb = 0;
        for (int k = 0; k < RBITS; k++) begin
            a = s % NRO;
            b = (s / 256) % NRO;
            if (a == b) b = (a + 1) % NRO;
            r[k] = freqOf(a) > freqOf(b);
            la = a;
            lb = b;
            s = modelStep(s);
        end
        return r;
    endfunction

    task automatic setPeriods(input real p0, input real p1, input real p2, input real p3);
        perNs[0] = p0; perNs[1] = p1; perNs[2] = p2; perNs[3] = p3;
        for (int i = 0; i < NRO; i++) roOn[i] = 1'b1;
        #200;
    endtask

    // Runs one evaluation, poking start and challenge mid-run to show they are ignored.
    task automatic applyStimulus(input logic [15:0] ch, output int lat, output bit busyAcc, output bit validAcc);
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyAcc = busy;
        validAcc = respValid;
        lat = 0;
        while (lat < LAT + 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 50) begin
                start = 1'b1;
                challenge = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        if (!done) checkOutput("doneTimeout", 32'(lat), 32'(LAT));
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] ch, input bit checkCounts);
        int lat, la, lb;
        bit busyAcc, validAcc;
        logic [RBITS-1:0] exp;
        exp = modelResp(ch, la, lb);
        applyStimulus(ch, lat, busyAcc, validAcc);
        checkOutput({tag, ".busyRise"}, 32'(busyAcc), 32'd1);
        checkOutput({tag, ".validClr"}, 32'(validAcc), 32'd0);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(LAT));
        checkOutput({tag, ".response"}, 32'(response), 32'(exp));
        checkOutput({tag, ".respValid"}, 32'(respValid), 32'd1);
        checkOutput({tag, ".busyFall"}, 32'(busy), 32'd0);
        if (checkCounts) begin
            checkRange({tag, ".cntA"}, int'(lastCntA), expCount(la) - 2, expCount(la) + 2);
            checkRange({tag, ".cntB"}, int'(lastCntB), expCount(lb) - 2, expCount(lb) + 2);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".respHold"}, 32'(response), 32'(exp));
    endtask

    initial begin
        logic [RBITS-1:0] r0, rSeed;
        int lat;
        bit busyAcc, validAcc;
        real pool [4];

        setPeriods(30.0, 20.0, 40.0, 45.0);
        #23;
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.response", 32'(response), 32'd0);
        checkOutput("rst.respValid", 32'(respValid), 32'd0);
        checkOutput("rst.cntA", 32'(lastCntA), 32'd0);
        checkOutput("rst.cntB", 32'(lastCntB), 32'd0);
        rstN = 1'b1;
        #20;

        runAndCheck("pair12", 16'h0201, 1'b1);
        checkOutput("pair12.bit0", 32'(response[0]), 32'd1);
        r0 = response;

        runAndCheck("sameIdx", 16'h0101, 1'b1);
        checkOutput("sameIdx.bit0", 32'(response[0]), 32'(r0[0]));

        runAndCheck("zeroSeed", 16'h0000, 1'b1);
        r0 = response;
        runAndCheck("aceSeed", 16'hACE1, 1'b1);
        rSeed = response;
        checkOutput("zeroVsAce", 32'(rSeed), 32'(r0));

        for (int i = 0; i < NRO; i++) roOn[i] = 1'b0;
        #200;
        runAndCheck("stuck", 16'($urandom), 1'b1);
        checkOutput("stuck.resp", 32'(response), 32'd0);
        checkOutput("stuck.cntA", 32'(lastCntA), 32'd0);
        checkOutput("stuck.cntB", 32'(lastCntB), 32'd0);

        setPeriods(20.0, 30.0, 45.0, 70.0);
        @(negedge clk);
        challenge = 16'h1302;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.response", 32'(response), 32'd0);
        checkOutput("abort.respValid", 32'(respValid), 32'd0);
        #10;
        rstN = 1'b1;
        #20;
        runAndCheck("afterAbort", 16'h1302, 1'b1);

        pool[0] = 20.0; pool[1] = 30.0; pool[2] = 45.0; pool[3] = 70.0;
        for (int it = 0; it < 5; it++) begin
            for (int i = NRO - 1; i > 0; i--) begin
                int j;
                real t;
                j = int'($urandom_range(i, 0));
                t = pool[i]; pool[i] = pool[j]; pool[j] = t;
            end
            setPeriods(pool[0], pool[1], pool[2], pool[3]);
            runAndCheck("rand", 16'($urandom), 1'b1);
        end

`ifdef PUF_MARGIN_EN
        setPeriods(30.0, 20.0, 21.0, 45.0);
        applyStimulus(16'h0201, lat, busyAcc, validAcc);
        checkOutput("margin.close", 32'(unreliable[0]), 32'd1);
        setPeriods(30.0, 20.0, 40.0, 45.0);
        applyStimulus(16'h0201, lat, busyAcc, validAcc);
        checkOutput("margin.far", 32'(unreliable[0]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
